// File: rtl/mul_accumulator.sv
// Sums NUM_TERMS unsigned products from a valid/ready stream and holds the result until it is taken.
// Optional MUL_ACC_SATURATE_EN: when defined, the accumulator clamps to all-ones on carry-out instead of wrapping.
module mul_accumulator #(
    parameter int PROD_W    = 8,
    parameter int NUM_TERMS = 4,
    parameter int ACC_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        term_cnt,
    output logic              ovf
);

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [ACC_W-1:0] sum_nx;
    logic [3:0]       cnt_nx;
    logic             ovf_nx;

    logic [ACC_W:0]   add_full;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic             last_term;
    logic             accept;

    assign in_ready  = (state == ACC) && !clr;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_term = (term_cnt == 4'(NUM_TERMS - 1));

    assign add_full = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign carry    = add_full[ACC_W];

`ifdef MUL_ACC_SATURATE_EN
    // Once clamped, any further non-zero add carries again, so acc stays pinned at all-ones.
    assign acc_add = carry ? '1 : add_full[ACC_W-1:0];
`else
    assign acc_add = add_full[ACC_W-1:0];
`endif

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        sum_nx   = sum;
        cnt_nx   = term_cnt;
        ovf_nx   = ovf;
        if (clr) begin
            state_nx = ACC;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (accept) begin
                        ovf_nx = ovf | carry;
                        if (last_term) begin
                            state_nx = DONE;
                            sum_nx   = acc_add;
                            acc_nx   = '0;
                            cnt_nx   = '0;
                        end else begin
                            acc_nx = acc_add;
                            cnt_nx = term_cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx = ACC;
                        ovf_nx   = 1'b0;
                    end
                end
                default: state_nx = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            sum      <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            sum      <= sum_nx;
            term_cnt <= cnt_nx;
            ovf      <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator with a scoreboard of expected results for the default instance.
// Extra instances cover ACC_W=9 overflow and NUM_TERMS=1.
module tb_mul_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [7:0] prod;
    logic       in_valid;
    logic       in_valid1;
    logic       out_ready;

    logic       in_ready, out_valid, ovf;
    logic [9:0] sum;
    logic [3:0] term_cnt;

    logic       in_ready9, out_valid9, ovf9;
    logic [8:0] sum9;
    logic [3:0] term_cnt9;

    logic       in_ready1, out_valid1, ovf1;
    logic [9:0] sum1;
    logic [3:0] term_cnt1;

    typedef struct packed {
        logic [9:0] s;
        logic       o;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model of the default instance
    bit   m_done = 0;
    int   m_cnt  = 0;
    int   m_acc  = 0;

`ifdef MUL_ACC_SATURATE_EN
    localparam logic [8:0] EXP9 = 9'd511;
`else
    localparam logic [8:0] EXP9 = 9'd388;
`endif

    always #5 clk = ~clk;

    mul_accumulator #(.PROD_W(8), .NUM_TERMS(4), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod), .in_valid(in_valid),
        .in_ready(in_ready), .sum(sum), .out_valid(out_valid), .out_ready(out_ready),
        .term_cnt(term_cnt), .ovf(ovf)
    );

    mul_accumulator #(.PROD_W(8), .NUM_TERMS(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod), .in_valid(in_valid),
        .in_ready(in_ready9), .sum(sum9), .out_valid(out_valid9), .out_ready(out_ready),
        .term_cnt(term_cnt9), .ovf(ovf9)
    );

    mul_accumulator #(.PROD_W(8), .NUM_TERMS(1), .ACC_W(10)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod), .in_valid(in_valid1),
        .in_ready(in_ready1), .sum(sum1), .out_valid(out_valid1), .out_ready(out_ready),
        .term_cnt(term_cnt1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_done = 0;
        m_cnt  = 0;
        m_acc  = 0;
        q.delete();
    endtask

    // One clock cycle with current inputs; entered and left at posedge+1.
    task automatic tick();
        exp_t e;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_done && !clr});
        if (m_done && out_ready && !clr) begin
            chk("scoreboard_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sum", {22'd0, sum}, {22'd0, e.s});
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
            end
        end
        if (clr) begin
            model_reset();
        end else if (!m_done) begin
            if (in_valid) begin
                m_acc += int'(prod);
                m_cnt++;
                if (m_cnt == 4) begin
                    q.push_back('{s: 10'(m_acc % 1024), o: (m_acc > 1023)});
                    m_done = 1;
                    m_cnt  = 0;
                    m_acc  = 0;
                end
            end
        end else if (out_ready) begin
            m_done = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
        chk("term_cnt", {28'd0, term_cnt}, m_cnt);
    endtask

    task automatic drive(input logic v, input logic [7:0] p);
        in_valid = v;
        prod     = p;
    endtask

    initial begin
        logic [7:0] basic[4];
        logic [7:0] gapv[10];
        logic [7:0] gapp[10];
        basic = '{8'd3, 8'd5, 8'd7, 8'd9};
        gapv  = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1};
        gapp  = '{8'd1, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd4};

        rst = 1'b1; clr = 1'b0; prod = '0; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", {22'd0, sum}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_term_cnt", {28'd0, term_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic back-to-back: 3,5,7,9 -> 24, out_valid exactly one cycle after the 4th accept
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, basic[i]);
            tick();
        end
        drive(1'b0, 8'd0);
        chk("basic_sum", {22'd0, sum}, 32'd24);
        chk("basic_ovf", {31'd0, ovf}, 32'd0);
        tick();
        tick();

        // Async reset after 2 terms
        drive(1'b1, 8'd50); tick();
        drive(1'b1, 8'd60); tick();
        drive(1'b0, 8'd0);
        rst = 1'b1;
        #2;
        chk("midrst_sum", {22'd0, sum}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_term_cnt", {28'd0, term_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure with 4x225; ACC_W=9 instance sees the same stream and overflows
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, 8'd225);
            tick();
        end
        chk("ovf9_sum", {23'd0, sum9}, {23'd0, EXP9});
        chk("ovf9_flag", {31'd0, ovf9}, 32'd1);
        drive(1'b1, 8'd7);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("bp_sum_held", {22'd0, sum}, 32'd900);
            chk("bp_ovf", {31'd0, ovf}, 32'd0);
        end
        chk("ovf9_held", {23'd0, sum9}, {23'd0, EXP9});
        out_ready = 1'b1;
        tick();
        chk("ovf9_cleared", {31'd0, ovf9}, 32'd0);
        chk("ovf9_taken", {31'd0, out_valid9}, 32'd0);
        tick();
        chk("bp_resume_cnt", {28'd0, term_cnt}, 32'd1);

        // clr with in_valid: no accept, partial sum dropped, sum keeps last value
        drive(1'b0, 8'd0);
        clr = 1'b1; tick(); clr = 1'b0;
        drive(1'b1, 8'd10); tick();
        drive(1'b1, 8'd20); tick();
        drive(1'b1, 8'd30);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_sum_kept", {22'd0, sum}, 32'd900);
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, 8'd1);
            tick();
        end
        drive(1'b0, 8'd0);
        chk("clr_sum4", {22'd0, sum}, 32'd4);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_done_sum_kept", {22'd0, sum}, 32'd4);
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, 8'd1);
            tick();
        end
        drive(1'b0, 8'd0);
        tick();

        // Stall gaps: term_cnt advances only on accepts
        for (int unsigned i = 0; i < 10; i++) begin
            drive(gapv[i][0], gapp[i]);
            tick();
        end
        drive(1'b0, 8'd0);
        chk("gap_sum", {22'd0, sum}, 32'd10);
        tick();

        // NUM_TERMS=1: every accept completes a result
        out_ready = 1'b0;
        prod = 8'd42;
        in_valid1 = 1'b1;
        #1;
        chk("nt1_ready", {31'd0, in_ready1}, 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("nt1_out_valid", {31'd0, out_valid1}, 32'd1);
        chk("nt1_sum", {22'd0, sum1}, 32'd42);
        chk("nt1_busy", {31'd0, in_ready1}, 32'd0);
        chk("nt1_term_cnt", {28'd0, term_cnt1}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("nt1_taken", {31'd0, out_valid1}, 32'd0);
        chk("nt1_ready_again", {31'd0, in_ready1}, 32'd1);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
